// File: rtl/byte_sink_pkg.sv
// Shared definitions for the byte/strobe sink: byte width and capture FSM states.
package byte_sink_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURE  = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_e;

endpackage

// File: rtl/byte_sink_fifo.sv
// Synchronous byte FIFO with an extra pointer bit so that count, full and empty
// all come straight from the pointer difference.
module byte_sink_fifo
  import byte_sink_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [BYTE_W-1:0]       wdata_i,
  input  logic                    pop_i,
  output logic [BYTE_W-1:0]       rdata_o,
  output logic                    push_ok_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_q, rd_q;
  logic              pop_ok;
  logic [BYTE_W-1:0] mem_q [DEPTH];

  assign count_o   = wr_q - rd_q;
  assign empty_o   = (wr_q == rd_q);
  assign full_o    = (count_o == (AW+1)'(DEPTH));
  assign pop_ok    = pop_i && !empty_o;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO is still accepted.
  assign push_ok_o = push_i && (!full_o || pop_ok);
  assign rdata_o   = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok_o) wr_q <= wr_q + 1'b1;
      if (pop_ok)    rd_q <= rd_q + 1'b1;
    end
  end

  // NOTE: storage has no reset; contents are only observable once written, so a reset would only cost area.
  always_ff @(posedge clk) begin
    if (push_ok_o) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/byte_sink_capture.sv
// Byte/strobe sink: synchronises 'send', captures one byte per pulse into a FIFO and counts frames.
// Optional macro BYTE_SINK_CHECKSUM_EN adds a per-frame XOR checksum output.
module byte_sink_capture
  import byte_sink_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BYTE_W-1:0]       data,
  input  logic                    send,
  input  logic                    rd_en,
  output logic [BYTE_W-1:0]       rd_data,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic [7:0]              frame_cnt,
  output logic                    frame_done,
  output logic                    overflow
`ifdef BYTE_SINK_CHECKSUM_EN
  ,
  output logic [BYTE_W-1:0]       checksum
`endif
);

  logic              send_meta_q, send_s_q, send_prev_q;
  logic [1:0]        primed_q;
  logic              send_rise;
  state_e            state_q;
  logic [BYTE_W-1:0] data_q;
  logic              push_q, push_ok;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q;

  // primed_q holds off edge detection until the synchroniser carries a real sample, so a
  // strobe already high when reset releases never looks like a fresh 0->1 edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      send_meta_q <= 1'b0;
      send_s_q    <= 1'b0;
      send_prev_q <= 1'b1;
      primed_q    <= 2'b00;
    end else begin
      send_meta_q <= send;
      send_s_q    <= send_meta_q;
      primed_q    <= {primed_q[0], 1'b1};
      if (primed_q[1]) send_prev_q <= send_s_q;
    end
  end

  assign send_rise = primed_q[1] && send_s_q && !send_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      push_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (send_rise) begin
            state_q <= ST_CAPTURE;
            data_q  <= data;
            push_q  <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          state_q <= ST_WAIT_LOW;
          push_q  <= 1'b0;
        end
        ST_WAIT_LOW: begin
          if (!send_s_q) state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          push_q  <= 1'b0;
        end
      endcase
    end
  end

  byte_sink_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push_q),
    .wdata_i   (data_q),
    .pop_i     (rd_en),
    .rdata_o   (rd_data),
    .push_ok_o (push_ok),
    .empty_o   (empty),
    .full_o    (full),
    .count_o   (count)
  );

  // A completed frame restarts on the next accepted byte, which becomes byte 1 of the new frame.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = frame_done_q;
    if (push_ok) begin
      frame_cnt_d  = frame_done_q ? 8'd1 : frame_cnt_q + 8'd1;
      frame_done_d = (frame_cnt_d == 8'(FRAME_LEN));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      if (push_q && !push_ok) overflow_q <= 1'b1;
    end
  end

  assign frame_cnt  = frame_cnt_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

`ifdef BYTE_SINK_CHECKSUM_EN
  logic [BYTE_W-1:0] checksum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if (push_ok) begin
      checksum_q <= frame_done_q ? data_q : (checksum_q ^ data_q);
    end
  end

  assign checksum = checksum_q;
`endif

endmodule
